// File: rtl/rggen_apb_bridge_if.sv
// ---------------------------------------------------------------------------
// rggen_rtl_pkg / rggen_bus_if
// Purpose : shared bus types and the rggen register bus interface used
//           between bus bridges (initiator) and the register block.
// Package : rggen_direction (RGGEN_READ/RGGEN_WRITE),
//           rggen_status (OKAY/EXOKAY/SLAVE_ERROR/DECODE_ERROR).
// Interface signals:
//   request       initiator -> target  transfer request, held until done
//   address       initiator -> target  byte address
//   direction     initiator -> target  read or write
//   write_data    initiator -> target  write data
//   write_strobe  initiator -> target  byte enables for writes
//   done          target -> initiator  one-cycle completion
//   read_data     target -> initiator  read data, valid with done
//   status        target -> initiator  response status, valid with done
// ---------------------------------------------------------------------------
package rggen_rtl_pkg;
  typedef enum logic {
    RGGEN_READ  = 1'b0,
    RGGEN_WRITE = 1'b1
  } rggen_direction;

  // Bit 1 set means an error response.
  typedef enum logic [1:0] {
    RGGEN_OKAY         = 2'b00,
    RGGEN_EXOKAY       = 2'b01,
    RGGEN_SLAVE_ERROR  = 2'b10,
    RGGEN_DECODE_ERROR = 2'b11
  } rggen_status;
endpackage

interface rggen_bus_if
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int BUS_WIDTH     = 32
);
  logic                     request;
  logic [ADDRESS_WIDTH-1:0] address;
  rggen_direction           direction;
  logic [BUS_WIDTH-1:0]     write_data;
  logic [BUS_WIDTH/8-1:0]   write_strobe;
  logic                     done;
  logic [BUS_WIDTH-1:0]     read_data;
  rggen_status              status;

  modport master (
    output request, address, direction, write_data, write_strobe,
    input  done, read_data, status
  );

  modport slave (
    input  request, address, direction, write_data, write_strobe,
    output done, read_data, status
  );
endinterface

// File: rtl/rggen_apb_bridge.sv
// ---------------------------------------------------------------------------
// rggen_apb_bridge
// Purpose : APB slave to rggen bus master bridge. One APB transfer at a time
//           is captured, issued as a single rggen bus request, and the
//           register block's response is returned with a one-cycle pready.
// Optional: define RGGEN_APB_BRIDGE_TIMEOUT_EN to force an error response
//           after TIMEOUT_CYCLES request cycles without done.
// Ports   :
//   clk, rst_n                 clock, asynchronous active-low reset
//   psel, penable, paddr,
//   pwrite, pwdata, pstrb      APB request side
//   pready, prdata, pslverr    APB response side (prdata/pslverr are zero
//                              outside the pready cycle)
//   bus_if                     rggen_bus_if master port
// ---------------------------------------------------------------------------
module rggen_apb_bridge
  import rggen_rtl_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
)(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic [ADDRESS_WIDTH-1:0] paddr,
  input  logic                    pwrite,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic                    pready,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pslverr,
  rggen_bus_if.master             bus_if
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESPONSE
  } state_e;

  state_e                  state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] address_reg, address_next;
  logic                    write_reg, write_next;
  logic [DATA_WIDTH-1:0]   write_data_reg, write_data_next;
  logic [STRB_WIDTH-1:0]   write_strobe_reg, write_strobe_next;
  logic                    pready_reg, pready_next;
  logic [DATA_WIDTH-1:0]   prdata_reg, prdata_next;
  logic                    pslverr_reg, pslverr_next;
  logic                    bus_error;

  // An invalid TIMEOUT_CYCLES shows up as this named scope in the hierarchy.
  if (TIMEOUT_CYCLES < 1) begin : g_invalid_timeout_cycles
  end

  // Error responses are the two status codes with bit 1 set.
  assign bus_error = bus_if.status inside {RGGEN_SLAVE_ERROR, RGGEN_DECODE_ERROR};

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
  localparam int COUNT_WIDTH = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  logic [COUNT_WIDTH-1:0] timeout_count_reg, timeout_count_next;
  logic                   timeout_hit;

  // The count is the number of BUSY cycles already spent without done, so
  // the request is held for exactly TIMEOUT_CYCLES cycles.
  assign timeout_hit = (timeout_count_reg == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_count_reg <= '0;
    end else begin
      timeout_count_reg <= timeout_count_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      address_reg      <= '0;
      write_reg        <= 1'b0;
      write_data_reg   <= '0;
      write_strobe_reg <= '0;
      pready_reg       <= 1'b0;
      prdata_reg       <= '0;
      pslverr_reg      <= 1'b0;
    end else begin
      state_reg        <= state_next;
      address_reg      <= address_next;
      write_reg        <= write_next;
      write_data_reg   <= write_data_next;
      write_strobe_reg <= write_strobe_next;
      pready_reg       <= pready_next;
      prdata_reg       <= prdata_next;
      pslverr_reg      <= pslverr_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    address_next      = address_reg;
    write_next        = write_reg;
    write_data_next   = write_data_reg;
    write_strobe_next = write_strobe_reg;
    // Response registers are only non-zero for the single RESPONSE cycle.
    pready_next       = 1'b0;
    prdata_next       = '0;
    pslverr_next      = 1'b0;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    timeout_count_next = timeout_count_reg;
`endif

    case (state_reg)
      IDLE: begin
        // Capture on psel alone so the request starts right after setup;
        // penable is not needed to commit the transfer.
        if (psel) begin
          state_next        = BUSY;
          address_next      = paddr;
          write_next        = pwrite;
          write_data_next   = pwrite ? pwdata : '0;
          write_strobe_next = pwrite ? pstrb  : '0;
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
          timeout_count_next = '0;
`endif
        end
      end
      BUSY: begin
        // done has priority over a timeout landing in the same cycle.
        if (bus_if.done) begin
          state_next   = RESPONSE;
          pready_next  = 1'b1;
          prdata_next  = write_reg ? '0 : bus_if.read_data;
          pslverr_next = bus_error;
        end
`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next   = RESPONSE;
          pready_next  = 1'b1;
          pslverr_next = 1'b1;
        end else begin
          timeout_count_next = timeout_count_reg + 1'b1;
        end
`endif
      end
      RESPONSE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request is decoded from state so the async reset clears it immediately.
  assign bus_if.request      = (state_reg == BUSY);
  assign bus_if.address      = address_reg;
  assign bus_if.direction    = write_reg ? RGGEN_WRITE : RGGEN_READ;
  assign bus_if.write_data   = write_data_reg;
  assign bus_if.write_strobe = write_strobe_reg;

  assign pready  = pready_reg;
  assign prdata  = prdata_reg;
  assign pslverr = pslverr_reg;

endmodule

// File: tb/tb_rggen_apb_bridge.sv
// ---------------------------------------------------------------------------
// tb_rggen_apb_bridge
// Drives APB transfers into rggen_apb_bridge, emulates the register block on
// bus_if with a per-transfer done delay, and scores responses and bus-side
// request fields against expectations queued when each transfer is issued.
// ---------------------------------------------------------------------------
module tb_rggen_apb_bridge;
  import rggen_rtl_pkg::*;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic [AW-1:0] paddr = '0;
  logic          pwrite = 1'b0;
  logic [DW-1:0] pwdata = '0;
  logic [SW-1:0] pstrb = '0;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  always #5 clk = ~clk;

  rggen_bus_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(DW)) bus_if ();

  rggen_apb_bridge #(
    .ADDRESS_WIDTH (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .psel   (psel),
    .penable(penable),
    .paddr  (paddr),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pstrb  (pstrb),
    .pready (pready),
    .prdata (prdata),
    .pslverr(pslverr),
    .bus_if (bus_if)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [DW-1:0] prdata;
    logic          pslverr;
    int            n;
  } exp_t;

  typedef struct {
    int            n;       // done in the n-th request cycle; 0 = never
    logic [DW-1:0] rdata;
    logic [1:0]    status;
  } resp_t;

  exp_t  exp_q[$];
  resp_t resp_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // ---------------- register block responder ----------------
  initial begin
    int    rcnt;
    resp_t cur;
    rcnt = 0;
    cur  = '{n: 0, rdata: '0, status: 2'b00};
    bus_if.done      = 1'b0;
    bus_if.read_data = '0;
    bus_if.status    = RGGEN_OKAY;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n || !bus_if.request) begin
        rcnt = 0;
        bus_if.done      = 1'b0;
        bus_if.read_data = $urandom;
        bus_if.status    = rggen_status'(2'($urandom_range(0, 3)));
      end else begin
        rcnt++;
        if (rcnt == 1) begin
          if (resp_q.size() > 0) cur = resp_q.pop_front();
          else cur = '{n: 0, rdata: '0, status: 2'b00};
        end
        bus_if.done = (cur.n != 0) && (rcnt == cur.n);
        if (bus_if.done) begin
          bus_if.read_data = cur.rdata;
          bus_if.status    = rggen_status'(cur.status);
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int   req_cnt;
    logic prev_req, prev_rdy;
    exp_t e;
    req_cnt  = 0;
    prev_req = 1'b0;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        req_cnt  = 0;
        prev_req = 1'b0;
        prev_rdy = 1'b0;
      end else begin
        if (bus_if.request) begin
          req_cnt++;
          if (req_cnt == 1 && exp_q.size() > 0) begin
            e = exp_q[0];
            check("bus_address", 64'(bus_if.address), 64'(e.addr));
            check("bus_direction", 64'(bus_if.direction), 64'(e.write ? RGGEN_WRITE : RGGEN_READ));
            check("bus_write_data", 64'(bus_if.write_data), 64'(e.wdata));
            check("bus_write_strobe", 64'(bus_if.write_strobe), 64'(e.strb));
          end
        end
        if (pready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_pready", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            $display("xfer addr=0x%04h write=%0d prdata=0x%08h pslverr=%0d req_cycles=%0d",
                     e.addr, e.write, prdata, pslverr, req_cnt);
            check("prdata", 64'(prdata), 64'(e.prdata));
            check("pslverr", 64'(pslverr), 64'(e.pslverr));
            check("request_cycles", 64'(req_cnt), 64'(e.n));
            check("pready_follows_request", 64'(prev_req), 64'(1));
            check("request_low_in_pready", 64'(bus_if.request), 64'(0));
          end
          check("pready_single_cycle", 64'(prev_rdy), 64'(0));
          req_cnt = 0;
        end else begin
          check("idle_response_zero", 64'({pslverr, prdata}), 64'(0));
        end
        prev_req = bus_if.request;
        prev_rdy = pready;
      end
    end
  end

  // ---------------- APB master ----------------
  // Called at #1 after a rising edge; returns at #1 after the edge that
  // starts the cycle following pready, leaving the APB bus idle.
  task automatic apb_xfer(input logic [AW-1:0] addr, input logic write,
                          input logic [DW-1:0] wdata, input logic [SW-1:0] strb,
                          input int n, input logic [DW-1:0] rdata,
                          input logic [1:0] status, input bit scramble);
    exp_t e;
    resp_q.push_back('{n: n, rdata: rdata, status: status});
    e.addr    = addr;
    e.write   = write;
    e.wdata   = write ? wdata : '0;
    e.strb    = write ? strb : '0;
    e.prdata  = (n == 0 || write) ? '0 : rdata;
    e.pslverr = (n == 0) ? 1'b1 : status[1];
    e.n       = (n == 0) ? TO : n;
    exp_q.push_back(e);
    psel    = 1'b1;
    penable = 1'b0;
    paddr   = addr;
    pwrite  = write;
    pwdata  = wdata;
    pstrb   = strb;
    @(posedge clk);
    #1;
    check("request_after_setup", 64'(bus_if.request), 64'(1));
    check("address_after_setup", 64'(bus_if.address), 64'(addr));
    penable = 1'b1;
    if (scramble) begin
      paddr  = AW'($urandom);
      pwrite = 1'($urandom);
      pwdata = $urandom;
      pstrb  = SW'($urandom);
    end
    for (int i = 0; i < 600; i++) begin
      if (pready) break;
      @(posedge clk);
      #1;
    end
    if (!pready) check("pready_timeout", 64'(pready), 64'(1));
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    bit stuck;
    logic [1:0] st;
    repeat (3) @(posedge clk);
    #1;
    check("reset_request", 64'(bus_if.request), 64'(0));
    check("reset_pready", 64'(pready), 64'(0));
    check("reset_prdata", 64'(prdata), 64'(0));
    check("reset_pslverr", 64'(pslverr), 64'(0));
    check("reset_address", 64'(bus_if.address), 64'(0));
    check("reset_write_data", 64'(bus_if.write_data), 64'(0));
    check("reset_write_strobe", 64'(bus_if.write_strobe), 64'(0));
    check("reset_direction", 64'(bus_if.direction), 64'(RGGEN_READ));
    rst_n = 1'b1;
    idle(2);

    // Directed write and read.
    apb_xfer(16'h0010, 1'b1, 32'hDEADBEEF, 4'hF, 2, 32'h0, 2'b00, 1'b0);
    idle(1);
    apb_xfer(16'h0024, 1'b0, 32'hCAFEF00D, 4'hA, 3, 32'h12345678, 2'b00, 1'b0);
    idle(1);

    // Status mapping.
    for (int s = 0; s < 4; s++) begin
      st = 2'(s);
      apb_xfer(16'h0030, 1'b0, 32'h0, 4'h0, 1, 32'hA5A50000 | 32'(s), st, 1'b0);
      idle(1);
    end

    // Back-to-back write then read.
    apb_xfer(16'h0000, 1'b1, 32'h11223344, 4'h3, 1, 32'h0, 2'b00, 1'b0);
    apb_xfer(16'h0004, 1'b0, 32'h0, 4'h0, 2, 32'h55667788, 2'b00, 1'b0);
    idle(2);

    // Reset two cycles into BUSY; the transfer is dropped.
    resp_q.push_back('{n: 50, rdata: 32'hBAD0BAD0, status: 2'b00});
    psel  = 1'b1;
    paddr = 16'h0040;
    pwrite = 1'b1;
    pwdata = 32'h0BADF00D;
    pstrb  = 4'hF;
    @(posedge clk);
    #1;
    penable = 1'b1;
    @(posedge clk);
    #1;
    check("busy_before_reset", 64'(bus_if.request), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_request", 64'(bus_if.request), 64'(0));
    check("async_reset_pready", 64'(pready), 64'(0));
    check("async_reset_write_data", 64'(bus_if.write_data), 64'(0));
    @(posedge clk);
    #1;
    psel    = 1'b0;
    penable = 1'b0;
    rst_n   = 1'b1;
    idle(1);
    apb_xfer(16'h0008, 1'b0, 32'h0, 4'h0, 2, 32'h0F0F1234, 2'b00, 1'b0);
    idle(1);

    // Randomized traffic, some back-to-back, with APB inputs scrambled
    // during the access phase.
    for (int t = 0; t < 40; t++) begin
      apb_xfer(AW'($urandom), 1'($urandom), $urandom, SW'($urandom),
               int'($urandom_range(1, 6)), $urandom, 2'($urandom_range(0, 3)), 1'b1);
      if ($urandom_range(0, 1) == 1) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

`ifdef RGGEN_APB_BRIDGE_TIMEOUT_EN
    apb_xfer(16'h0050, 1'b0, 32'h0, 4'h0, 0, 32'hFFFFFFFF, 2'b00, 1'b0);
    idle(2);
`else
    resp_q.push_back('{n: 0, rdata: '0, status: 2'b00});
    psel   = 1'b1;
    paddr  = 16'h0050;
    pwrite = 1'b0;
    @(posedge clk);
    #1;
    penable = 1'b1;
    stuck = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!bus_if.request || pready) stuck = 1'b0;
      @(posedge clk);
      #1;
    end
    check("no_timeout_request_held", 64'(stuck), 64'(1));
    rst_n = 1'b0;
    psel    = 1'b0;
    penable = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(2);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
